// File: rtl/ram_arb_stn2tft_if.sv
// rtl/ram_arb_stn2tft_if.sv - requester and frame-RAM bundle for the stn2tft RAM arbiter
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface ram_arb_stn2tft_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_vld;
   logic [DATA_W-1:0] rd_data;

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;

   logic              hs_req;
   logic              hs_we;
   logic [ADDR_W-1:0] hs_addr;
   logic [DATA_W-1:0] hs_wdata;
   logic              hs_gnt;
   logic              hs_vld;
   logic [DATA_W-1:0] hs_rdata;

   logic              err_clr;
   logic              err_oor;

   logic              ram_ce;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  hs_req, hs_we, hs_addr, hs_wdata, err_clr, ram_rdata,
      output rd_gnt, rd_vld, rd_data, wr_gnt, hs_gnt, hs_vld, hs_rdata,
      output err_oor, ram_ce, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output hs_req, hs_we, hs_addr, hs_wdata, err_clr, ram_rdata,
      input  rd_gnt, rd_vld, rd_data, wr_gnt, hs_gnt, hs_vld, hs_rdata,
      input  err_oor, ram_ce, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_arb_stn2tft.sv
// rtl/ram_arb_stn2tft.sv - frame-RAM arbiter for TFT readout, STN capture and host port
// Starvation boosting, registered RAM drive, 2-stage read-return tags, out-of-range guard.
module ram_arb_stn2tft #(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 8,
   parameter int RAM_DEPTH   = 6144,
   parameter int WR_MAX_WAIT = 4,
   parameter int HS_MAX_WAIT = 16
) (
   input  logic                clk,
   input  logic                rst_x,
   ram_arb_stn2tft_if.slave    bus
);
   localparam int WRW_W = $clog2(WR_MAX_WAIT + 1);
   localparam int HSW_W = $clog2(HS_MAX_WAIT + 1);

   logic [WRW_W-1:0]  r_wr_wait;
   logic [HSW_W-1:0]  r_hs_wait;
   logic              r_ram_ce, r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_t1_rd, r_t1_hs, r_t1_oor;
   logic              r_t2_rd, r_t2_hs, r_t2_oor;
   logic              r_err_oor;
   logic [DATA_W-1:0] r_rd_hold, r_hs_hold;

   logic              w_rd_oor, w_wr_oor, w_hs_oor;
   logic              w_wr_boost, w_hs_boost;
   logic              w_rd_g, w_wr_g, w_hs_g, w_any;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_sel_oor, w_sel_we;
   logic [DATA_W-1:0] w_ret_data;

   assign w_rd_oor = {{(32-ADDR_W){1'b0}}, bus.rd_addr} >= 32'(RAM_DEPTH);
   assign w_wr_oor = {{(32-ADDR_W){1'b0}}, bus.wr_addr} >= 32'(RAM_DEPTH);
   assign w_hs_oor = {{(32-ADDR_W){1'b0}}, bus.hs_addr} >= 32'(RAM_DEPTH);

   assign w_wr_boost = bus.wr_req && (r_wr_wait == WRW_W'(WR_MAX_WAIT));
   assign w_hs_boost = bus.hs_req && (r_hs_wait == HSW_W'(HS_MAX_WAIT));

   // Grants are gated by reset so nothing is granted while rst_x is low.
   always_comb begin
      w_rd_g = 1'b0;
      w_wr_g = 1'b0;
      w_hs_g = 1'b0;
      if (rst_x) begin
         if (w_wr_boost)      w_wr_g = 1'b1;
         else if (w_hs_boost) w_hs_g = 1'b1;
         else if (bus.rd_req) w_rd_g = 1'b1;
         else if (bus.wr_req) w_wr_g = 1'b1;
         else if (bus.hs_req) w_hs_g = 1'b1;
      end
   end

   assign w_any = w_rd_g | w_wr_g | w_hs_g;

   always_comb begin
      w_sel_addr  = bus.rd_addr;
      w_sel_wdata = bus.wr_data;
      w_sel_oor   = 1'b0;
      w_sel_we    = 1'b0;
      if (w_wr_g) begin
         w_sel_addr  = bus.wr_addr;
         w_sel_wdata = bus.wr_data;
         w_sel_oor   = w_wr_oor;
         w_sel_we    = 1'b1;
      end else if (w_hs_g) begin
         w_sel_addr  = bus.hs_addr;
         w_sel_wdata = bus.hs_wdata;
         w_sel_oor   = w_hs_oor;
         w_sel_we    = bus.hs_we;
      end else if (w_rd_g) begin
         w_sel_oor   = w_rd_oor;
      end
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_wr_wait   <= '0;
         r_hs_wait   <= '0;
         r_ram_ce    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_t1_rd     <= 1'b0;
         r_t1_hs     <= 1'b0;
         r_t1_oor    <= 1'b0;
         r_t2_rd     <= 1'b0;
         r_t2_hs     <= 1'b0;
         r_t2_oor    <= 1'b0;
         r_err_oor   <= 1'b0;
         r_rd_hold   <= '0;
         r_hs_hold   <= '0;
      end else begin
         if (bus.wr_req && !w_wr_g) begin
            if (r_wr_wait != WRW_W'(WR_MAX_WAIT)) r_wr_wait <= r_wr_wait + 1'b1;
         end else begin
            r_wr_wait <= '0;
         end
         if (bus.hs_req && !w_hs_g) begin
            if (r_hs_wait != HSW_W'(HS_MAX_WAIT)) r_hs_wait <= r_hs_wait + 1'b1;
         end else begin
            r_hs_wait <= '0;
         end

         // An out-of-range winner still occupies the slot but never reaches the RAM.
         r_ram_ce <= w_any && !w_sel_oor;
         r_ram_we <= w_any && !w_sel_oor && w_sel_we;
         if (w_any)             r_ram_addr  <= w_sel_addr;
         if (w_any && w_sel_we) r_ram_wdata <= w_sel_wdata;

         r_t1_rd  <= w_rd_g;
         r_t1_hs  <= w_hs_g && !bus.hs_we;
         r_t1_oor <= w_sel_oor;
         r_t2_rd  <= r_t1_rd;
         r_t2_hs  <= r_t1_hs;
         r_t2_oor <= r_t1_oor;

         if (w_any && w_sel_oor) r_err_oor <= 1'b1;
         else if (bus.err_clr)   r_err_oor <= 1'b0;

         if (r_t2_rd) r_rd_hold <= w_ret_data;
         if (r_t2_hs) r_hs_hold <= w_ret_data;
      end
   end

   assign w_ret_data = r_t2_oor ? '0 : bus.ram_rdata;

   assign bus.rd_gnt    = w_rd_g;
   assign bus.wr_gnt    = w_wr_g;
   assign bus.hs_gnt    = w_hs_g;
   assign bus.rd_vld    = r_t2_rd;
   assign bus.hs_vld    = r_t2_hs;
   assign bus.rd_data   = r_t2_rd ? w_ret_data : r_rd_hold;
   assign bus.hs_rdata  = r_t2_hs ? w_ret_data : r_hs_hold;
   assign bus.err_oor   = r_err_oor;
   assign bus.ram_ce    = r_ram_ce;
   assign bus.ram_we    = r_ram_we;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_wdata = r_ram_wdata;
endmodule
